// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared encodings for the MIPS datapath: ALU operation codes driven on
//   Op_Alu, R-type funct codes, the two-bit ALUOp codes produced by the main
//   control unit, and bit positions inside the 5-bit control bundle
//   {RegWrite, MemRead, MemWrite, MemToReg, Branch}.
//   Used by the ALU, the control unit and the ID/EX pipeline register.
package mips_pkg;

  // ALU operation codes (Op_Alu)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL1 = 4'b1111;  // Op_2 shifted left by one

  // R-type funct field codes
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALUOp codes from the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw / sw / addi
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode Funct
  localparam logic [1:0] ALUOP_SLTI  = 2'b11;

  // Control bundle layout
  localparam int CTL_W        = 5;
  localparam int CTL_REGWRITE = 4;
  localparam int CTL_MEMREAD  = 3;
  localparam int CTL_MEMWRITE = 2;
  localparam int CTL_MEMTOREG = 1;
  localparam int CTL_BRANCH   = 0;

  // Strip the architecturally visible side effects (register and memory
  // writes) from a control bundle so an illegal op travels as a bubble.
  function automatic logic [CTL_W-1:0] ctl_kill(input logic [CTL_W-1:0] ctl);
    logic [CTL_W-1:0] r;
    r = ctl;
    r[CTL_REGWRITE] = 1'b0;
    r[CTL_MEMWRITE] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec
//   Combinational ALU control decoder: maps ALUOp / Funct / Shamt to the
//   4-bit ALU operation and flags unsupported R-type encodings.
// Ports
//   alu_op_i   in  2  ALUOp from main control
//   funct_i    in  6  R-type funct field
//   shamt_i    in  5  R-type shamt field
//   op_alu_o   out 4  ALU operation (ADD for anything illegal)
//   illegal_o  out 1  R-type with unsupported funct, or sll with shamt != 1
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] shamt_i,
  output logic [3:0] op_alu_o,
  output logic       illegal_o
);

  always_comb begin
    op_alu_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD:  op_alu_o = ALU_ADD;
      ALUOP_SUB:  op_alu_o = ALU_SUB;
      ALUOP_SLTI: op_alu_o = ALU_SLT;
      default: begin
        case (funct_i)
          FUNCT_ADD: op_alu_o = ALU_ADD;
          FUNCT_SUB: op_alu_o = ALU_SUB;
          FUNCT_AND: op_alu_o = ALU_AND;
          FUNCT_OR:  op_alu_o = ALU_OR;
          FUNCT_SLT: op_alu_o = ALU_SLT;
          FUNCT_SLL: begin
            // The ALU only implements a fixed shift-by-one.
            if (shamt_i == 5'd1) begin
              op_alu_o = ALU_SLL1;
            end else begin
              illegal_o = 1'b1;
            end
          end
          default:   illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register. Captures decoded operands and control, derives
//   the ALU operation, applies the ALUSrc immediate mux and the RegDst
//   destination mux, and presents stable values to the EX stage.
//   Valid/ready handshake on both sides with downstream stall and flush.
// Ports
//   Clk, Rst_n                 clock, synchronous active-low reset
//   In_Valid / In_Ready        upstream handshake (In_Ready combinational)
//   Flush                      drop held and incoming instruction
//   ALUOp, Funct, Shamt        ALU control inputs
//   ALUSrc, RegDst             operand / destination mux selects
//   Rs_Data, Rt_Data, Imm      operands
//   Rt, Rd                     register addresses
//   Ctl_In                     {RegWrite, MemRead, MemWrite, MemToReg, Branch}
//   Out_Valid / Out_Ready      downstream handshake
//   Op_1, Op_2, Op_Alu         to ALU
//   Store_Data, Wr_Reg         to later stages
//   Ctl_Out, Bad_Op            registered control and illegal-op flag
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Flush,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic [4:0]        Shamt,
  input  logic              ALUSrc,
  input  logic              RegDst,
  input  logic [DATA_W-1:0] Rs_Data,
  input  logic [DATA_W-1:0] Rt_Data,
  input  logic [15:0]       Imm,
  input  logic [REG_AW-1:0] Rt,
  input  logic [REG_AW-1:0] Rd,
  input  logic [CTL_W-1:0]  Ctl_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Op_1,
  output logic [DATA_W-1:0] Op_2,
  output logic [3:0]        Op_Alu,
  output logic [DATA_W-1:0] Store_Data,
  output logic [REG_AW-1:0] Wr_Reg,
  output logic [CTL_W-1:0]  Ctl_Out,
  output logic              Bad_Op
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] op_1_q, op_1_d;
  logic [DATA_W-1:0] op_2_q, op_2_d;
  logic [3:0]        op_alu_q, op_alu_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
  logic [CTL_W-1:0]  ctl_q, ctl_d;
  logic              bad_op_q, bad_op_d;

  logic [3:0] dec_op_alu;
  logic       dec_illegal;
  logic       load;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op_i  (ALUOp),
    .funct_i   (Funct),
    .shamt_i   (Shamt),
    .op_alu_o  (dec_op_alu),
    .illegal_o (dec_illegal)
  );

  // Flush forces readiness so the incoming (wrong-path) instruction is consumed.
  assign In_Ready = !out_valid_q || Out_Ready || Flush;
  assign load     = In_Valid && In_Ready && !Flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    op_1_d       = op_1_q;
    op_2_d       = op_2_q;
    op_alu_d     = op_alu_q;
    store_data_d = store_data_q;
    wr_reg_d     = wr_reg_q;
    ctl_d        = ctl_q;
    bad_op_d     = bad_op_q;
    if (Flush) begin
      // Operand registers are left alone; only the parts that could cause
      // side effects downstream are cleared.
      out_valid_d = 1'b0;
      ctl_d       = '0;
      bad_op_d    = 1'b0;
    end else if (load) begin
      out_valid_d  = 1'b1;
      op_1_d       = Rs_Data;
      op_2_d       = ALUSrc ? {{(DATA_W-16){Imm[15]}}, Imm} : Rt_Data;
      op_alu_d     = dec_op_alu;
      store_data_d = Rt_Data;
      wr_reg_d     = RegDst ? Rd : Rt;
      ctl_d        = dec_illegal ? ctl_kill(Ctl_In) : Ctl_In;
      bad_op_d     = dec_illegal;
    end else if (Out_Ready) begin
      // Drained with nothing new: data registers keep stale contents.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      out_valid_q  <= 1'b0;
      op_1_q       <= '0;
      op_2_q       <= '0;
      op_alu_q     <= ALU_AND;
      store_data_q <= '0;
      wr_reg_q     <= '0;
      ctl_q        <= '0;
      bad_op_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      op_1_q       <= op_1_d;
      op_2_q       <= op_2_d;
      op_alu_q     <= op_alu_d;
      store_data_q <= store_data_d;
      wr_reg_q     <= wr_reg_d;
      ctl_q        <= ctl_d;
      bad_op_q     <= bad_op_d;
    end
  end

  assign Out_Valid  = out_valid_q;
  assign Op_1       = op_1_q;
  assign Op_2       = op_2_q;
  assign Op_Alu     = op_alu_q;
  assign Store_Data = store_data_q;
  assign Wr_Reg     = wr_reg_q;
  assign Ctl_Out    = ctl_q;
  assign Bad_Op     = bad_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Directed bench for the ID/EX register: reset, R-type and I-type capture,
//   stall/hold, flush, drain, illegal-op handling and reset during a stall.
//   Expected outputs are queued when an instruction is driven and compared
//   when it appears on the EX side.
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_Valid;
  logic        In_Ready;
  logic        Flush;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic        ALUSrc;
  logic        RegDst;
  logic [31:0] Rs_Data;
  logic [31:0] Rt_Data;
  logic [15:0] Imm;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [4:0]  Ctl_In;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Op_1;
  logic [31:0] Op_2;
  logic [3:0]  Op_Alu;
  logic [31:0] Store_Data;
  logic [4:0]  Wr_Reg;
  logic [4:0]  Ctl_Out;
  logic        Bad_Op;

  always #5 Clk = ~Clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Flush      (Flush),
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .Shamt      (Shamt),
    .ALUSrc     (ALUSrc),
    .RegDst     (RegDst),
    .Rs_Data    (Rs_Data),
    .Rt_Data    (Rt_Data),
    .Imm        (Imm),
    .Rt         (Rt),
    .Rd         (Rd),
    .Ctl_In     (Ctl_In),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Op_1       (Op_1),
    .Op_2       (Op_2),
    .Op_Alu     (Op_Alu),
    .Store_Data (Store_Data),
    .Wr_Reg     (Wr_Reg),
    .Ctl_Out    (Ctl_Out),
    .Bad_Op     (Bad_Op)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic [3:0]  alu;
    logic [4:0]  wr;
    logic [4:0]  ctl;
    logic        bad;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive one instruction on the decode side and queue its expected EX view.
  task automatic drive(input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [4:0] shamt, input logic alusrc,
                       input logic regdst, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm,
                       input logic [4:0] rta, input logic [4:0] rda,
                       input logic [4:0] ctl, input logic [3:0] exp_alu,
                       input logic exp_bad);
    exp_t e;
    ALUOp = aluop; Funct = funct; Shamt = shamt; ALUSrc = alusrc;
    RegDst = regdst; Rs_Data = rs; Rt_Data = rt; Imm = imm;
    Rt = rta; Rd = rda; Ctl_In = ctl; In_Valid = 1'b1;
    e.op1 = rs;
    e.op2 = alusrc ? 32'($signed(imm)) : rt;
    e.sd  = rt;
    e.alu = exp_alu;
    e.wr  = regdst ? rda : rta;
    e.ctl = exp_bad ? (ctl & 5'b01011) : ctl;
    e.bad = exp_bad;
    sb.push_back(e);
    $display("drive  aluop=%b funct=%b shamt=%0d alusrc=%b rs=%h rt=%h imm=%h ctl=%b",
             aluop, funct, shamt, alusrc, rs, rt, imm, ctl);
  endtask

  // Compare the EX side against the oldest queued entry.
  task automatic expect_out(input string tag, input bit pop);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s scoreboard empty, observed Out_Valid=%0b expected queued entry", tag, Out_Valid);
      return;
    end
    e = sb[0];
    if (pop) void'(sb.pop_front());
    chk({tag, ".valid"}, Out_Valid, 1);
    chk({tag, ".op1"},   Op_1, e.op1);
    chk({tag, ".op2"},   Op_2, e.op2);
    chk({tag, ".alu"},   Op_Alu, e.alu);
    chk({tag, ".sd"},    Store_Data, e.sd);
    chk({tag, ".wr"},    Wr_Reg, e.wr);
    chk({tag, ".ctl"},   Ctl_Out, e.ctl);
    chk({tag, ".bad"},   Bad_Op, e.bad);
    $display("output %s op1=%h op2=%h alu=%b wr=%0d ctl=%b bad=%b",
             tag, Op_1, Op_2, Op_Alu, Wr_Reg, Ctl_Out, Bad_Op);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, Out_Valid, 0);
    chk({tag, ".op1"},   Op_1, 0);
    chk({tag, ".op2"},   Op_2, 0);
    chk({tag, ".alu"},   Op_Alu, 0);
    chk({tag, ".sd"},    Store_Data, 0);
    chk({tag, ".wr"},    Wr_Reg, 0);
    chk({tag, ".ctl"},   Ctl_Out, 0);
    chk({tag, ".bad"},   Bad_Op, 0);
    $display("reset  %s valid=%b alu=%b", tag, Out_Valid, Op_Alu);
  endtask

  initial begin
    // Reset held two cycles while decode presents a live instruction.
    Rst_n = 1'b0; In_Valid = 1'b1; Out_Ready = 1'b1; Flush = 1'b0;
    ALUOp = 2'b10; Funct = 6'b100000; Shamt = 5'd0; ALUSrc = 1'b0; RegDst = 1'b1;
    Rs_Data = 32'hDEAD_BEEF; Rt_Data = 32'h1234_5678; Imm = 16'h8000;
    Rt = 5'd3; Rd = 5'd4; Ctl_In = 5'b11111;
    tick(); chk_reset("rst1");
    tick(); chk_reset("rst2");
    Rst_n = 1'b1; In_Valid = 1'b0;
    tick(); chk("idle.valid", Out_Valid, 0);

    // R-type add
    drive(2'b10, 6'b100000, 5'd0, 1'b0, 1'b1, 32'd5, 32'd7, 16'h0000, 5'd3, 5'd9,
          5'b10000, 4'b0010, 1'b0);
    #1 chk("add.in_ready", In_Ready, 1);
    tick(); In_Valid = 1'b0; expect_out("radd", 1);

    // lw with negative offset
    drive(2'b00, 6'b111111, 5'd0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0055, 16'hFFFC,
          5'd8, 5'd2, 5'b11010, 4'b0010, 1'b0);
    tick(); In_Valid = 1'b0; expect_out("lw", 1);
    tick(); chk("drain.valid", Out_Valid, 0);

    // Stall: beq captured, then held three cycles while 'and' waits
    drive(2'b01, 6'b000000, 5'd0, 1'b0, 1'b0, 32'd9, 32'd9, 16'h0004, 5'd1, 5'd1,
          5'b00001, 4'b0110, 1'b0);
    tick(); expect_out("beq", 0);
    Out_Ready = 1'b0;
    drive(2'b10, 6'b100100, 5'd0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0000,
          5'd5, 5'd6, 5'b10000, 4'b0000, 1'b0);
    #1 chk("stall.in_ready", In_Ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall_hold", 0);
    end
    Out_Ready = 1'b1;
    #1 chk("unstall.in_ready", In_Ready, 1);
    void'(sb.pop_front());  // beq leaves at this edge
    tick(); In_Valid = 1'b0; expect_out("and", 1);

    // Flush while stalled with a new instruction waiting
    drive(2'b10, 6'b100101, 5'd0, 1'b0, 1'b1, 32'h0000_00A0, 32'h0000_000B, 16'h0000,
          5'd10, 5'd11, 5'b10000, 4'b0001, 1'b0);
    tick(); expect_out("or", 0);
    Out_Ready = 1'b0;
    drive(2'b10, 6'b101010, 5'd0, 1'b0, 1'b1, 32'd1, 32'd2, 16'h0000, 5'd12, 5'd13,
          5'b10000, 4'b0111, 1'b0);
    tick(); expect_out("or_hold", 0);
    Flush = 1'b1;
    #1 chk("flush.in_ready", In_Ready, 1);
    tick(); Flush = 1'b0; In_Valid = 1'b0;
    sb.delete();  // held 'or' and incoming 'slt' are both discarded
    chk("flush.valid", Out_Valid, 0);
    chk("flush.ctl", Ctl_Out, 0);
    chk("flush.bad", Bad_Op, 0);
    Out_Ready = 1'b1;
    tick(); chk("postflush.valid", Out_Valid, 0);

    // Back-to-back stream including illegal encodings
    drive(2'b10, 6'b000000, 5'd2, 1'b0, 1'b1, 32'd0, 32'd3, 16'h0000, 5'd14, 5'd15,
          5'b10100, 4'b0010, 1'b1);
    tick();
    drive(2'b10, 6'b000000, 5'd1, 1'b0, 1'b1, 32'd0, 32'd3, 16'h0000, 5'd14, 5'd16,
          5'b10000, 4'b1111, 1'b0);
    expect_out("sll_shamt2", 1);
    tick();
    drive(2'b10, 6'b100111, 5'd0, 1'b0, 1'b1, 32'd4, 32'd5, 16'h0000, 5'd17, 5'd18,
          5'b11111, 4'b0010, 1'b1);
    expect_out("sll_shamt1", 1);
    tick();
    drive(2'b11, 6'b000000, 5'd0, 1'b1, 1'b0, 32'd7, 32'd0, 16'h8001, 5'd19, 5'd20,
          5'b10000, 4'b0111, 1'b0);
    expect_out("nor_illegal", 1);
    tick();
    drive(2'b10, 6'b100010, 5'd0, 1'b0, 1'b1, 32'd50, 32'd8, 16'h0000, 5'd21, 5'd22,
          5'b10000, 4'b0110, 1'b0);
    expect_out("slti", 1);
    tick();
    drive(2'b10, 6'b101010, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 16'h0000, 5'd23, 5'd24,
          5'b10000, 4'b0111, 1'b0);
    expect_out("rsub", 1);
    tick(); In_Valid = 1'b0; expect_out("rslt", 1);
    tick(); chk("drain2.valid", Out_Valid, 0);

    // Reset during a stall discards the held entry
    drive(2'b10, 6'b100000, 5'd0, 1'b0, 1'b1, 32'h11, 32'h22, 16'h0000, 5'd25, 5'd26,
          5'b10000, 4'b0010, 1'b0);
    tick(); Out_Ready = 1'b0; expect_out("pre_rst", 1);
    Rst_n = 1'b0;
    tick(); chk_reset("rst_stall");
    Rst_n = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
    tick(); chk("post_rst.valid", Out_Valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
